// File: rtl/fetch_queue.sv
// Instruction fetch unit: PC issue, one-cycle memory response capture and a DEPTH-entry fetch queue.
// Optional performance counters are enabled by defining FETCH_QUEUE_PERF_CNT_EN.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_halt,
    output logic            o_imem_rd_en,
    output logic [XLEN-1:0] o_imem_rd_addr,
    input  logic [XLEN-1:0] i_imem_rd_data,
    output logic            o_if_valid,
    input  logic            i_if_ready,
    output logic [XLEN-1:0] o_if_instr,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_pc_plus_4,
    output logic            o_halted
`ifdef FETCH_QUEUE_PERF_CNT_EN
    ,
    output logic [31:0]     o_fetch_cnt,
    output logic [31:0]     o_stall_cnt
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pending_q, pending_d;
    logic            halted_q, halted_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [CW-1:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    // Occupancy counts the in-flight response so a push can never land in a full queue.
    always_comb begin
        occupancy = count_q + CW'(pending_q);
        issue     = !rst && !halted_q && !i_halt && !i_redirect && (occupancy < CW'(DEPTH));
        push      = pending_q && !i_redirect;
        pop       = o_if_valid && i_if_ready && !i_redirect;
    end

    always_comb begin
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pending_d = pending_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        halted_d  = halted_q | i_halt;

        if (i_redirect) begin
            pc_d      = {i_redirect_pc[XLEN-1:2], 2'b00};
            pending_d = 1'b0;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end else begin
            pending_d = issue;
            if (issue) begin
                pend_pc_d = pc_q;
                pc_d      = pc_q + XLEN'(4);
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
            pending_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pending_q <= pending_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= i_imem_rd_data;
            pc_mem[wr_ptr_q]    <= pend_pc_q;
        end
    end

    assign o_imem_rd_en   = issue;
    assign o_imem_rd_addr = pc_q;
    assign o_if_valid     = (count_q != '0);
    assign o_if_instr     = instr_mem[rd_ptr_q];
    assign o_if_pc        = pc_mem[rd_ptr_q];
    assign o_if_pc_plus_4 = pc_mem[rd_ptr_q] + XLEN'(4);
    assign o_halted       = halted_q;

`ifdef FETCH_QUEUE_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (!halted_q && (occupancy >= CW'(DEPTH)) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle model plus scoreboard of expected queue entries,
// with directed scenarios for reset, back-pressure, redirect, halt and PC wrap.
module tb_fetch_queue;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_imem_rd_en;
    logic [31:0] o_imem_rd_addr;
    logic [31:0] i_imem_rd_data;
    logic        o_if_valid;
    logic        i_if_ready;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_pc_plus_4;
    logic        o_halted;
`ifdef FETCH_QUEUE_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    entry_t      sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    logic        m_pending;
    logic        m_halted;
    logic        exp_issue;
    int unsigned m_fetch;
    int unsigned m_stall;

    fetch_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .o_imem_rd_en  (o_imem_rd_en),
        .o_imem_rd_addr(o_imem_rd_addr),
        .i_imem_rd_data(i_imem_rd_data),
        .o_if_valid    (o_if_valid),
        .i_if_ready    (i_if_ready),
        .o_if_instr    (o_if_instr),
        .o_if_pc       (o_if_pc),
        .o_if_pc_plus_4(o_if_pc_plus_4),
        .o_halted      (o_halted)
`ifdef FETCH_QUEUE_PERF_CNT_EN
        ,
        .o_fetch_cnt   (o_fetch_cnt),
        .o_stall_cnt   (o_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory answers one cycle after issue; garbage otherwise so a wrongly timed push shows up.
    always @(posedge clk)
        i_imem_rd_data <= o_imem_rd_en ? mem_word(o_imem_rd_addr) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_rd_en", {31'd0, o_imem_rd_en}, 32'd0);
            check("rst_valid", {31'd0, o_if_valid}, 32'd0);
            check("rst_halted", {31'd0, o_halted}, 32'd0);
            check("rst_rd_addr", o_imem_rd_addr, RESET_PC);
            m_pc      = RESET_PC;
            m_pend_pc = RESET_PC;
            m_pending = 1'b0;
            m_halted  = 1'b0;
            m_fetch   = 0;
            m_stall   = 0;
            sb.delete();
        end else begin
            exp_issue = !m_halted && !i_halt && !i_redirect &&
                        ((sb.size() + int'(m_pending)) < DEPTH);
            check("rd_en", {31'd0, o_imem_rd_en}, {31'd0, exp_issue});
            check("rd_addr", o_imem_rd_addr, m_pc);
            check("halted", {31'd0, o_halted}, {31'd0, m_halted});
            check("if_valid", {31'd0, o_if_valid}, {31'd0, sb.size() != 0});
            if (sb.size() != 0) begin
                check("if_instr", o_if_instr, sb[0].instr);
                check("if_pc", o_if_pc, sb[0].pc);
                check("if_pc_plus_4", o_if_pc_plus_4, sb[0].pcp4);
            end
`ifdef FETCH_QUEUE_PERF_CNT_EN
            check("fetch_cnt", o_fetch_cnt, m_fetch);
            check("stall_cnt", o_stall_cnt, m_stall);
`endif
            if (!m_halted && ((sb.size() + int'(m_pending)) >= DEPTH)) m_stall++;
            if (i_redirect) begin
                sb.delete();
                m_pending = 1'b0;
                m_pc      = {i_redirect_pc[31:2], 2'b00};
            end else begin
                if (sb.size() != 0 && i_if_ready) void'(sb.pop_front());
                if (m_pending) begin
                    sb.push_back('{instr: mem_word(m_pend_pc), pc: m_pend_pc,
                                   pcp4: m_pend_pc + 32'd4});
                    m_fetch++;
                end
                m_pending = exp_issue;
                if (exp_issue) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
            end
            m_halted = m_halted | i_halt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst           = 1'b1;
        i_redirect    = 1'b0;
        i_halt        = 1'b0;
        i_if_ready    = ready;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target, input logic halt);
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        i_halt        = halt;
        tick();
        i_redirect = 1'b0;
        i_halt     = 1'b0;
    endtask

    initial begin
        int unsigned issues;
        rst           = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_halt        = 1'b0;
        i_if_ready    = 1'b1;

        // Reset release with continuous ready: addresses 0,4,8 and head PC 0 on the third cycle.
        tick();
        do_reset(1'b1);
        #1;
        check("c1_rd_en", {31'd0, o_imem_rd_en}, 32'd1);
        check("c1_rd_addr", o_imem_rd_addr, 32'h0);
        tick();
        #1;
        check("c2_rd_addr", o_imem_rd_addr, 32'h4);
        check("c2_valid", {31'd0, o_if_valid}, 32'd0);
        tick();
        #1;
        check("c3_rd_addr", o_imem_rd_addr, 32'h8);
        check("c3_valid", {31'd0, o_if_valid}, 32'd1);
        check("c3_if_pc", o_if_pc, 32'h0);
        repeat (15) tick();

        // No ready from reset: exactly DEPTH issues, then head PC 0 held.
        do_reset(1'b0);
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (o_imem_rd_en) issues++;
            tick();
        end
        check("full_issue_count", issues, DEPTH);
        check("full_head_pc", o_if_pc, 32'h0);
        check("full_rd_en", {31'd0, o_imem_rd_en}, 32'd0);

        // Random back-pressure with occasional redirects.
        for (int i = 0; i < 80; i++) begin
            i_if_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) redirect_to($urandom, 1'b0);
            else tick();
        end

        // Queue holds 8,C with 10 in flight, then a misaligned redirect.
        i_if_ready = 1'b0;
        redirect_to(32'h8, 1'b0);
        tick();
        tick();
        tick();
        i_if_ready = 1'b1;
        redirect_to(32'h103, 1'b0);
        #1;
        check("redir_valid", {31'd0, o_if_valid}, 32'd0);
        check("redir_rd_addr", o_imem_rd_addr, 32'h100);
        repeat (6) tick();

        // PC wraps past the top of the address space.
        redirect_to(32'hFFFF_FFF8, 1'b0);
        tick();
        tick();
        #1;
        check("wrap_rd_addr", o_imem_rd_addr, 32'h0);
        repeat (6) tick();

        // Halt with 0x1C in flight: it still reaches decode, 0x20 is never issued.
        redirect_to(32'h1C, 1'b0);
        tick();
        i_halt = 1'b1;
        #1;
        check("halt_rd_en", {31'd0, o_imem_rd_en}, 32'd0);
        check("halt_rd_addr", o_imem_rd_addr, 32'h20);
        tick();
        i_halt = 1'b0;
        #1;
        check("halt_flag", {31'd0, o_halted}, 32'd1);
        check("halt_head_pc", o_if_pc, 32'h1C);
        repeat (5) tick();
        redirect_to(32'h40, 1'b0);
        #1;
        check("halt_redir_flag", {31'd0, o_halted}, 32'd1);
        check("halt_redir_addr", o_imem_rd_addr, 32'h40);
        repeat (3) tick();

        // Redirect and halt together.
        do_reset(1'b1);
        repeat (5) tick();
        redirect_to(32'h200, 1'b1);
        #1;
        check("both_halted", {31'd0, o_halted}, 32'd1);
        check("both_valid", {31'd0, o_if_valid}, 32'd0);
        check("both_rd_addr", o_imem_rd_addr, 32'h200);
        repeat (3) tick();

        // Asynchronous reset with three entries queued and one in flight.
        do_reset(1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, o_if_valid}, 32'd0);
        check("arst_rd_en", {31'd0, o_imem_rd_en}, 32'd0);
        check("arst_rd_addr", o_imem_rd_addr, RESET_PC);
`ifdef FETCH_QUEUE_PERF_CNT_EN
        check("arst_fetch_cnt", o_fetch_cnt, 32'd0);
        check("arst_stall_cnt", o_stall_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
